// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO. Frames are start bit, DATA_BITS
// data bits LSB first, optional parity bit and STOP_BITS stop bits, paced by baud_tick.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_tick,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_ready,
  output logic                          overflow,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD_FLIP  = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   tx_q, tx_d;
  logic                   tx_done_q, tx_done_d;

  logic                   full, empty, push, pop;
  logic [DATA_BITS-1:0]   head;

  // Full/empty come from registered state only, so a same-cycle pop never frees room.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = wr_en & ~full;
  assign pop   = (state_q == S_IDLE) & ~empty;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en & full;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage array has no reset; the cleared pointers and count make stale words unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (!empty) state_d = S_START;
      S_START:  if (baud_tick) state_d = S_DATA;
      S_DATA:   if (baud_tick && bit_cnt_q == BIT_LAST)
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (baud_tick) state_d = S_STOP;
      S_STOP:   if (baud_tick && stop_cnt_q == STOP_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Parity is taken from the word as it leaves the FIFO; the shifter is consumed later.
        if (!empty) begin
          shift_d  = head;
          parity_d = (^head) ^ ODD_FLIP;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d      = 1'b0;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            if (PARITY != 0) begin
              tx_d = parity_q;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) tx_done_d = 1'b1;
          else                         stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign tx_done    = tx_done_q;
  assign overflow   = overflow_q;
  assign wr_ready   = ~full;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, 8E1, 8O1 and 7N2 instances share clock, reset and
// baud_tick; each frame is checked tick by tick against hand-derived bit patterns.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic [3:0] wr_en_r;
  logic [7:0] wd8 [3];
  logic [6:0] wd7;

  logic       tx_o [4];
  logic       busy_o [4];
  logic       done_o [4];
  logic       ovf_o [4];
  logic       rdy_o [4];
  logic [2:0] cnt_o [4];

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_fifo u_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .wr_en(wr_en_r[0]), .wr_data(wd8[0]),
    .wr_ready(rdy_o[0]), .overflow(ovf_o[0]), .tx(tx_o[0]), .busy(busy_o[0]),
    .tx_done(done_o[0]), .fifo_count(cnt_o[0])
  );

  uart_tx_fifo #(.PARITY(2)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .wr_en(wr_en_r[1]), .wr_data(wd8[1]),
    .wr_ready(rdy_o[1]), .overflow(ovf_o[1]), .tx(tx_o[1]), .busy(busy_o[1]),
    .tx_done(done_o[1]), .fifo_count(cnt_o[1])
  );

  uart_tx_fifo #(.PARITY(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .wr_en(wr_en_r[2]), .wr_data(wd8[2]),
    .wr_ready(rdy_o[2]), .overflow(ovf_o[2]), .tx(tx_o[2]), .busy(busy_o[2]),
    .tx_done(done_o[2]), .fifo_count(cnt_o[2])
  );

  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .wr_en(wr_en_r[3]), .wr_data(wd7),
    .wr_ready(rdy_o[3]), .overflow(ovf_o[3]), .tx(tx_o[3]), .busy(busy_o[3]),
    .tx_done(done_o[3]), .fifo_count(cnt_o[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one word into unit u; returns at the negedge after the sampling edge.
  task automatic push_word(input int u, input logic [8:0] w);
    if (u == 3) wd7 = w[6:0];
    else        wd8[u] = w[7:0];
    wr_en_r[u] = 1'b1;
    @(negedge clk);
    wr_en_r[u] = 1'b0;
  endtask

  // One baud period of 16 clocks; returns right after the edge that saw the tick.
  task automatic tick();
    repeat (15) @(negedge clk);
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
  endtask

  // exp[k-1] is the line level after tick k; tx_done must pulse at tick n+1 only.
  task automatic check_frame(input int u, input int n, input logic [11:0] exp, input string tag);
    for (int k = 1; k <= n + 1; k++) begin
      tick();
      if (k <= n) check($sformatf("%s tx@%0d", tag, k), tx_o[u], exp[k-1]);
      check($sformatf("%s done@%0d", tag, k), done_o[u], (k == n + 1));
    end
    check({tag, " busy_end"}, busy_o[u], 1'b0);
  endtask

  function automatic logic [11:0] f8n1(input logic [7:0] w);
    return {2'b00, 1'b1, w, 1'b0};
  endfunction

  initial begin
    rst_n     = 1'b1;
    baud_tick = 1'b0;
    wr_en_r   = '0;
    wd7       = '0;
    for (int i = 0; i < 3; i++) wd8[i] = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    check("rst tx",       tx_o[0],   1'b1);
    check("rst busy",     busy_o[0], 1'b0);
    check("rst done",     done_o[0], 1'b0);
    check("rst overflow", ovf_o[0],  1'b0);
    check("rst wr_ready", rdy_o[0],  1'b1);
    check("rst count",    cnt_o[0],  3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 8N1 frame of 0x55.
    push_word(0, 9'h055);
    check("8n1 count_push", cnt_o[0],  3'd1);
    check("8n1 busy_pre",   busy_o[0], 1'b0);
    @(negedge clk);
    check("8n1 busy_pop",   busy_o[0], 1'b1);
    check("8n1 count_pop",  cnt_o[0],  3'd0);
    check("8n1 tx_idle",    tx_o[0],   1'b1);
    check_frame(0, 10, 12'h2AA, "8n1_55");

    // Parity variants and 7-bit / 2-stop frame.
    push_word(1, 9'h055);
    check_frame(1, 11, 12'h4AA, "8e1_55");
    push_word(2, 9'h055);
    check_frame(2, 11, 12'h6AA, "8o1_55");
    push_word(1, 9'h007);
    check_frame(1, 11, 12'h60E, "8e1_07");
    push_word(3, 9'h07F);
    check_frame(3, 10, 12'h3FE, "7n2_7f");

    // Five back-to-back pushes while idle, then one too many.
    push_word(0, 9'h0A5);
    check("burst count1", cnt_o[0], 3'd1);
    push_word(0, 9'h03C);
    check("burst count2", cnt_o[0], 3'd1);
    check("burst busy",   busy_o[0], 1'b1);
    push_word(0, 9'h00F);
    push_word(0, 9'h0F0);
    push_word(0, 9'h081);
    check("burst count5", cnt_o[0], 3'd4);
    check("burst full",   rdy_o[0], 1'b0);
    check("burst no_ovf", ovf_o[0], 1'b0);
    push_word(0, 9'h0FF);
    check("burst ovf",       ovf_o[0], 1'b1);
    check("burst count_ovf", cnt_o[0], 3'd4);
    @(negedge clk);
    check("burst ovf_pulse", ovf_o[0], 1'b0);

    check_frame(0, 10, f8n1(8'hA5), "q0_a5");
    // Push against a full FIFO on the very clock that pops the next word.
    push_word(0, 9'h099);
    check("pop_ovf ovf",   ovf_o[0],  1'b1);
    check("pop_ovf count", cnt_o[0],  3'd3);
    check("pop_ovf busy",  busy_o[0], 1'b1);
    check_frame(0, 10, f8n1(8'h3C), "q1_3c");
    check_frame(0, 10, f8n1(8'h0F), "q2_0f");
    check_frame(0, 10, f8n1(8'hF0), "q3_f0");
    check_frame(0, 10, f8n1(8'h81), "q4_81");
    check("drain count", cnt_o[0], 3'd0);
    tick();
    check("drain tx",   tx_o[0],   1'b1);
    check("drain busy", busy_o[0], 1'b0);
    check("drain done", done_o[0], 1'b0);

    // Reset during data bit 3 with two words queued.
    push_word(0, 9'h000);
    @(negedge clk);
    push_word(0, 9'h000);
    push_word(0, 9'h000);
    for (int k = 0; k < 5; k++) tick();
    check("mid tx_low", tx_o[0],  1'b0);
    check("mid count",  cnt_o[0], 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst tx",    tx_o[0],   1'b1);
    check("mid rst count", cnt_o[0],  3'd0);
    check("mid rst busy",  busy_o[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_rst tx%0d", k),   tx_o[0],   1'b1);
      check($sformatf("post_rst busy%0d", k), busy_o[0], 1'b0);
    end
    check("post_rst count", cnt_o[0], 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO. It is the next generation of the single-byte serial transmitter and sits between the bus-side write logic and the TX pin. It takes the same external baud_tick pulse from the shared baud generator. Frame format is configurable: data width, parity mode and stop-bit count. Firmware can queue several words; frames go out back-to-back, and a per-frame completion pulse is produced.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
baud_tick  in  1  one-clk pulse per bit period
wr_en  in  1  push request
wr_data  in  DATA_BITS  word to queue
wr_ready  out  1  FIFO not full
overflow  out  1  one-clk pulse: wr_en seen while FIFO full
tx  out  1  serial line; idles high
busy  out  1  frame in progress (any state other than IDLE)
tx_done  out  1  one-clk pulse at end of final stop bit
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently held

Behaviour:
- Reset (rst_n low, asynchronous): tx=1, busy=0, tx_done=0, overflow=0, wr_ready=1, fifo_count=0, FSM=IDLE, FIFO pointers cleared.
- Reset asserted mid-frame aborts the frame: tx is forced high immediately and all queued data is discarded.
- FIFO push:
  - Accepted when wr_en=1 and wr_ready=1; fifo_count increments on the next edge.
  - wr_en while full: word dropped, overflow pulses for 1 clk, FIFO contents unchanged.
  - wr_ready is computed from registered state. A pop in the same cycle does not make room for a push in that cycle.
- Simultaneous push and pop while not full: fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP. Each bit is driven on a baud_tick and held until the next baud_tick.
- IDLE:
  - If the FIFO is non-empty, pop the head word into the shift register, set busy=1, go to START. tx stays 1.
  - A word pushed into an empty FIFO is popped on the following clk.
- START: on baud_tick, tx<=0, bit counter cleared, go to DATA.
- DATA:
  - Each baud_tick after the start bit drives the next data bit, LSB first.
  - After DATA_BITS data bits have been driven, the next tick moves on to parity or stop as below.
- Parity step (runs when PARITY≠0, at the tick ending the last data bit):
  - tx<=parity bit, go to PARITY.
  - Even mode: parity bit = XOR of the data bits.
  - Odd mode: parity bit = the inverse of that XOR.
  - The parity bit is computed from the latched word, never from wr_data.
- Stop step (at the tick ending the last data bit, or the parity bit when parity is on): tx<=1, stop counter cleared, go to STOP.
- STOP:
  - Each baud_tick completes one stop bit.
  - On the tick completing stop bit STOP_BITS: tx_done=1 for exactly 1 clk, busy<=0, go to IDLE.
  - If the FIFO is non-empty, the next word is popped on the following clk. Its start bit begins at the next baud_tick, so consecutive frames have no idle gap.
- Frame length in baud ticks: 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- baud_tick in IDLE: ignored.
- baud_tick on the same clk as a pop: consumed by IDLE, so the start bit begins at the following tick.
- Pushes during transmission never disturb the frame in flight.
- tx is a registered output and is glitch-free.

Test Plan:
- Default parameters (8N1), push 0x55, tick every 16 clk. Required tx at successive ticks: 0,1,0,1,0,1,0,1,0,1. tx_done pulses once at the 11th tick; busy goes high to low.
- PARITY=2 with 0x55 → parity bit 0; PARITY=1 with 0x55 → 1; PARITY=2 with 0x07 → 1. Frame length is 11 ticks.
- STOP_BITS=2, DATA_BITS=7, push 0x7F: frame is start 0, seven 1s, two stop 1s. tx_done arrives 10 ticks after the start bit; tx is never low after the start bit.
- FIFO_DEPTH=4, push 5 words back-to-back while idle. The 5th push is accepted, because the first word was popped. A 6th push produces overflow=1 and is dropped. All 5 words appear on tx in order, with no idle tick between frames and 5 tx_done pulses.
- Deassert rst_n during DATA bit 3 with 2 words queued: tx=1 immediately, fifo_count=0, busy=0. After release, tx stays 1 and no frame is sent.
- Assert wr_en with fifo_count=FIFO_DEPTH on the same clk as a pop: overflow pulses and fifo_count becomes FIFO_DEPTH-1.
